// File: rtl/operand_fetch_ctrl.sv
// Operand fetch sequencer: pops data/weight FIFOs into a 2-entry skid buffer.
// Optional conv bias prefetch is enabled by defining BIAS_FETCH_EN.
module operand_fetch_ctrl #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        op_type,
  input  logic [CNT_W-1:0]  op_num,
  input  logic              data_fifo_empty,
  input  logic [DATA_W-1:0] data_fifo_dout,
  output logic              data_fifo_rd_en,
  input  logic              weight_fifo_empty,
  input  logic [DATA_W-1:0] weight_fifo_dout,
  output logic              weight_fifo_rd_en,
  output logic              opnd_valid,
  input  logic              opnd_ready,
  output logic [DATA_W-1:0] opnd_data,
  output logic [DATA_W-1:0] opnd_weight,
  output logic              opnd_last,
  output logic              busy,
  output logic              done,
`ifdef BIAS_FETCH_EN
  input  logic              bias_fifo_empty,
  input  logic [DATA_W-1:0] bias_fifo_dout,
  output logic              bias_fifo_rd_en,
  output logic [DATA_W-1:0] bias_out,
  output logic              bias_valid,
`endif
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_DONE
`ifdef BIAS_FETCH_EN
    , S_BIAS
`endif
  } state_e;

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] w;
    logic [DATA_W-1:0] d;
  } ent_t;

  localparam logic [CNT_W-1:0] ONE = 1;

  state_e           state_q, state_d;
  logic             conv_q;
  logic [CNT_W-1:0] num_q;
  logic [CNT_W-1:0] issued_q;
  logic [CNT_W-1:0] accepted_q;
  logic             infl_q;
  logic             infl_last_q;
  ent_t             buf_q [2];
  ent_t             buf_d [2];
  logic [1:0]       cnt_q, cnt_d;
  logic             err_q;

  logic             legal, conv_in, accept;
  logic             pop, pop_last, hs;
  logic [1:0]       occ;
  logic [CNT_W:0]   acc_nx;
  ent_t             in_ent, head;

  assign legal   = (op_type >= 3'd1) && (op_type <= 3'd4);
  assign conv_in = (op_type == 3'd1) || (op_type == 3'd2);
  assign accept  = (state_q == S_IDLE) && start && legal;

  assign occ      = cnt_q + {1'b0, infl_q};
  assign pop_last = (issued_q == num_q - ONE);
  assign pop      = (state_q == S_FETCH) && !rst
                  && (issued_q != num_q)
                  && !data_fifo_empty
                  && (!conv_q || !weight_fifo_empty)
                  && (occ < 2'd2);

  assign data_fifo_rd_en   = pop;
  assign weight_fifo_rd_en = pop && conv_q;

  // The in-flight word bypasses the buffer so a pair is visible on dout's cycle.
  assign in_ent = '{last: infl_last_q,
                    w: conv_q ? weight_fifo_dout : '0,
                    d: data_fifo_dout};
  assign head   = (cnt_q != 2'd0) ? buf_q[0]
                : (infl_q ? in_ent : '0);

  assign opnd_valid  = (cnt_q != 2'd0) || infl_q;
  assign opnd_data   = head.d;
  assign opnd_weight = head.w;
  assign opnd_last   = head.last;
  assign hs          = opnd_valid && opnd_ready;

  assign acc_nx = {1'b0, accepted_q} + {{CNT_W{1'b0}}, hs};

  assign busy = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done = (state_q == S_DONE);
  assign err  = err_q;

  always_comb begin
    buf_d = buf_q;
    cnt_d = cnt_q;
    if (hs && cnt_q != 2'd0) begin
      buf_d[0] = buf_q[1];
      cnt_d    = cnt_q - 2'd1;
    end
    if (infl_q && !(hs && cnt_q == 2'd0)) begin
      buf_d[cnt_d[0]] = in_ent;
      cnt_d           = cnt_d + 2'd1;
    end
  end

`ifdef BIAS_FETCH_EN
  logic              bias_infl_q;
  logic              bias_valid_q;
  logic [DATA_W-1:0] bias_q;
  logic              bias_pop;

  assign bias_pop = (state_q == S_BIAS) && !rst
                  && !bias_infl_q && !bias_fifo_empty;
  assign bias_fifo_rd_en = bias_pop;
  assign bias_out        = bias_q;
  assign bias_valid      = bias_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      bias_infl_q  <= 1'b0;
      bias_valid_q <= 1'b0;
      bias_q       <= '0;
    end else begin
      bias_infl_q <= bias_pop;
      if (bias_infl_q) begin
        bias_q       <= bias_fifo_dout;
        bias_valid_q <= 1'b1;
      end else if (state_q == S_DONE) begin
        bias_valid_q <= 1'b0;
      end
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept) begin
        // Zero-length ops complete straight out of DRAIN.
        if (op_num == '0) state_d = S_DRAIN;
`ifdef BIAS_FETCH_EN
        else if (conv_in) state_d = S_BIAS;
`endif
        else state_d = S_FETCH;
      end
`ifdef BIAS_FETCH_EN
      S_BIAS: if (bias_infl_q) state_d = S_FETCH;
`endif
      S_FETCH: if (pop && pop_last) state_d = S_DRAIN;
      S_DRAIN: if (acc_nx == {1'b0, num_q}) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      conv_q      <= 1'b0;
      num_q       <= '0;
      issued_q    <= '0;
      accepted_q  <= '0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      cnt_q       <= '0;
      buf_q[0]    <= '0;
      buf_q[1]    <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      err_q       <= (state_q == S_IDLE) && start && !legal;
      infl_q      <= pop;
      infl_last_q <= pop && pop_last;
      buf_q       <= buf_d;
      cnt_q       <= cnt_d;
      if (accept) begin
        conv_q     <= conv_in;
        num_q      <= op_num;
        issued_q   <= '0;
        accepted_q <= '0;
      end else begin
        if (pop) issued_q <= issued_q + ONE;
        if (hs)  accepted_q <= accepted_q + ONE;
      end
    end
  end

endmodule

// File: tb/tb_operand_fetch_ctrl.sv
// Bench for operand_fetch_ctrl: FIFO models, randomized ready/empty,
// and an expected-pair list derived from FIFO contents at command time.
module tb_operand_fetch_ctrl;
  localparam int DW = 16;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [2:0]    op_type;
  logic [CW-1:0] op_num;
  logic          data_fifo_empty, weight_fifo_empty;
  logic [DW-1:0] data_fifo_dout, weight_fifo_dout;
  logic          data_fifo_rd_en, weight_fifo_rd_en;
  logic          opnd_valid, opnd_ready, opnd_last;
  logic [DW-1:0] opnd_data, opnd_weight;
  logic          busy, done, err;
`ifdef BIAS_FETCH_EN
  logic          bias_fifo_empty = 1'b0;
  logic [DW-1:0] bias_fifo_dout = '0;
  logic          bias_fifo_rd_en, bias_valid;
  logic [DW-1:0] bias_out;
`endif

  always #5 clk = ~clk;

  operand_fetch_ctrl #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .op_type(op_type), .op_num(op_num),
    .data_fifo_empty(data_fifo_empty),
    .data_fifo_dout(data_fifo_dout),
    .data_fifo_rd_en(data_fifo_rd_en),
    .weight_fifo_empty(weight_fifo_empty),
    .weight_fifo_dout(weight_fifo_dout),
    .weight_fifo_rd_en(weight_fifo_rd_en),
    .opnd_valid(opnd_valid), .opnd_ready(opnd_ready),
    .opnd_data(opnd_data), .opnd_weight(opnd_weight),
    .opnd_last(opnd_last),
    .busy(busy), .done(done),
`ifdef BIAS_FETCH_EN
    .bias_fifo_empty(bias_fifo_empty),
    .bias_fifo_dout(bias_fifo_dout),
    .bias_fifo_rd_en(bias_fifo_rd_en),
    .bias_out(bias_out), .bias_valid(bias_valid),
`endif
    .err(err)
  );

  typedef struct packed {
    logic          last;
    logic [DW-1:0] w;
    logic [DW-1:0] d;
  } pair_t;

  logic [DW-1:0] dq[$];
  logic [DW-1:0] wq[$];
  pair_t got[$];
  pair_t exp_q[$];
  int    got_cyc[$];

  int cyc, done_n, done_cyc, err_n, err_cyc, busy_n;
  int npop_d, npop_w, nhs;
  int v_empty, v_wpool, v_lock, v_stall, v_hold, v_occ;
  int st_lo = -1;
  int st_hi = -2;
  bit op_conv, rnd_empty;
  bit prev_stall;
  pair_t prev_p;
  int checks = 0;
  int failures = 0;

  task automatic clear_stats();
    got.delete(); got_cyc.delete();
    cyc = 0; done_n = 0; done_cyc = -1;
    err_n = 0; err_cyc = -1; busy_n = 0;
    npop_d = 0; npop_w = 0; nhs = 0;
    v_empty = 0; v_wpool = 0; v_lock = 0;
    v_stall = 0; v_hold = 0; v_occ = 0;
    prev_stall = 0;
  endtask

  // One clock: drive empties, observe at negedge+1, apply FIFO pops after posedge.
  task automatic cycle();
    logic rdd, rdw;
    pair_t cur;
    bit win;
    win = (cyc >= st_lo) && (cyc <= st_hi);
    data_fifo_empty = (dq.size() == 0)
      || (rnd_empty && $urandom_range(3) == 0);
    weight_fifo_empty = (wq.size() == 0) || win
      || (rnd_empty && $urandom_range(3) == 0);
    #1;
    rdd = data_fifo_rd_en;
    rdw = weight_fifo_rd_en;
    cur = {opnd_last, opnd_weight, opnd_data};
    if (rdd && data_fifo_empty) v_empty++;
    if (rdw && weight_fifo_empty) v_empty++;
    if (!op_conv && rdw) v_wpool++;
    if (op_conv && (rdd != rdw)) v_lock++;
    if (win && (rdd || rdw)) v_stall++;
    if (prev_stall && (!opnd_valid || cur !== prev_p)) v_hold++;
    if (rdd && (npop_d - nhs) >= 2) v_occ++;
    prev_stall = opnd_valid && !opnd_ready;
    prev_p = cur;
    if (opnd_valid && opnd_ready) begin
      got.push_back(cur);
      got_cyc.push_back(cyc);
      nhs++;
    end
    if (rdd) npop_d++;
    if (rdw) npop_w++;
    if (done) begin
      done_n++;
      if (done_cyc < 0) done_cyc = cyc;
    end
    if (err) begin
      err_n++;
      if (err_cyc < 0) err_cyc = cyc;
    end
    if (busy) busy_n++;
    @(posedge clk);
    #1;
    if (rdd && dq.size() > 0) data_fifo_dout = dq.pop_front();
    if (rdw && wq.size() > 0) weight_fifo_dout = wq.pop_front();
    cyc++;
    @(negedge clk);
  endtask

  // Expected stream: the next num words of each FIFO, tagged last on the final one.
  task automatic build_exp(input bit conv, input int num);
    pair_t p;
    exp_q.delete();
    for (int i = 0; i < num; i++) begin
      p.d = (i < dq.size()) ? dq[i] : '0;
      p.w = (conv && i < wq.size()) ? wq[i] : '0;
      p.last = (i == num - 1);
      exp_q.push_back(p);
    end
  endtask

  task automatic set_ready(input int mode);
    if (mode == 0) opnd_ready = 1'b1;
    else if (mode == 1) opnd_ready = (cyc % 2 == 0);
    else opnd_ready = 1'($urandom_range(1));
  endtask

  task automatic run_op(input int typ, input int num, input int mode,
                        input bit restart, input int budget);
    clear_stats();
    op_conv = (typ == 1) || (typ == 2);
    build_exp(op_conv, num);
    op_type = 3'(typ);
    op_num = CW'(num);
    start = 1'b1;
    set_ready(mode);
    cycle();
    while (done_n == 0 && cyc < budget) begin
      start = 1'b0;
      if (restart && cyc == 2) begin
        start = 1'b1; op_type = 3'd7;
      end
      if (restart && cyc == 4) begin
        start = 1'b1; op_type = 3'd3; op_num = 2;
      end
      set_ready(mode);
      cycle();
    end
    start = 1'b0;
    repeat (3) begin
      opnd_ready = 1'b1;
      cycle();
    end
  endtask

  task automatic fill_pattern();
    dq.delete(); wq.delete();
    for (int i = 0; i < 32; i++) begin
      dq.push_back(i < 16 ? 16'h3c00 : 16'h4000);
      wq.push_back(i < 16 ? 16'h3c00 : 16'h4000);
    end
  endtask

  task automatic fill_random(input int n);
    dq.delete(); wq.delete();
    for (int i = 0; i < n; i++) begin
      dq.push_back(16'($urandom));
      wq.push_back(16'($urandom));
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op_type = '0; op_num = '0;
    opnd_ready = 1'b0;
    data_fifo_dout = '0; weight_fifo_dout = '0;
    clear_stats();
    cycle(); cycle();
    #1;
    checks++;
    if ({data_fifo_rd_en, weight_fifo_rd_en} !== 2'b00) begin
      failures++;
      $display("FAIL reset_pops got=%b exp=00",
               {data_fifo_rd_en, weight_fifo_rd_en});
    end
    checks++;
    if ({opnd_valid, opnd_last, opnd_data, opnd_weight} !== '0) begin
      failures++;
      $display("FAIL reset_opnd got v=%b d=%h w=%h exp 0",
               opnd_valid, opnd_data, opnd_weight);
    end
    checks++;
    if ({busy, done, err} !== 3'b000) begin
      failures++;
      $display("FAIL reset_status got=%b exp=000", {busy, done, err});
    end
    rst = 1'b0;
    cycle();
  endtask

  task automatic test_conv_stream();
    int bad;
    fill_pattern();
    run_op(2, 9, 0, 0, 60);
    checks++;
    if (got.size() !== 9) begin
      failures++;
      $display("FAIL conv_count got=%0d exp=9", got.size());
    end
    bad = 0;
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= got.size() || got[i] !== exp_q[i]) bad++;
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL conv_pairs bad=%0d exp=0", bad);
    end
    bad = 0;
    for (int i = 0; i < got_cyc.size(); i++)
      if (got_cyc[i] !== 2 + i) bad++;
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL conv_timing bad=%0d exp=0", bad);
    end
    checks++;
    if (done_cyc !== 11 || done_n !== 1) begin
      failures++;
      $display("FAIL conv_done cyc=%0d n=%0d exp cyc=11 n=1",
               done_cyc, done_n);
    end
    checks++;
    if (npop_d !== 9 || npop_w !== 9) begin
      failures++;
      $display("FAIL conv_pops d=%0d w=%0d exp=9", npop_d, npop_w);
    end
    checks++;
    if (busy_n !== 10) begin
      failures++;
      $display("FAIL conv_busy got=%0d exp=10", busy_n);
    end
  endtask

  task automatic test_ready_toggle();
    int bad;
    run_op(2, 9, 1, 0, 80);
    bad = 0;
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= got.size() || got[i] !== exp_q[i]) bad++;
    checks++;
    if (bad !== 0 || got.size() !== 9) begin
      failures++;
      $display("FAIL toggle_pairs bad=%0d n=%0d exp 0/9", bad, got.size());
    end
    checks++;
    if (v_hold !== 0) begin
      failures++;
      $display("FAIL toggle_hold got=%0d exp=0", v_hold);
    end
    checks++;
    if (v_occ !== 0 || v_empty !== 0 || v_lock !== 0) begin
      failures++;
      $display("FAIL toggle_rd occ=%0d emp=%0d lock=%0d exp=0",
               v_occ, v_empty, v_lock);
    end
    checks++;
    if (done_n !== 1 || npop_d !== 9) begin
      failures++;
      $display("FAIL toggle_done n=%0d pops=%0d exp 1/9", done_n, npop_d);
    end
  endtask

  task automatic test_maxpool();
    int bad;
    fill_random(16);
    run_op(3, 4, 0, 0, 40);
    checks++;
    if (npop_w !== 0 || v_wpool !== 0) begin
      failures++;
      $display("FAIL pool_wpop got=%0d exp=0", npop_w);
    end
    bad = 0;
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= got.size() || got[i] !== exp_q[i]) bad++;
    checks++;
    if (bad !== 0 || got.size() !== 4) begin
      failures++;
      $display("FAIL pool_pairs bad=%0d n=%0d exp 0/4", bad, got.size());
    end
    checks++;
    if (done_cyc !== 6 || done_n !== 1) begin
      failures++;
      $display("FAIL pool_done cyc=%0d n=%0d exp 6/1", done_cyc, done_n);
    end
  endtask

  task automatic test_weight_stall();
    int bad;
    fill_pattern();
    st_lo = 3; st_hi = 6;
    run_op(2, 9, 0, 0, 60);
    st_lo = -1; st_hi = -2;
    checks++;
    if (v_stall !== 0) begin
      failures++;
      $display("FAIL stall_rd got=%0d exp=0", v_stall);
    end
    bad = 0;
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= got.size() || got[i] !== exp_q[i]) bad++;
    checks++;
    if (bad !== 0 || got.size() !== 9) begin
      failures++;
      $display("FAIL stall_pairs bad=%0d n=%0d exp 0/9", bad, got.size());
    end
    checks++;
    if (done_cyc !== 15 || npop_d !== 9 || npop_w !== 9) begin
      failures++;
      $display("FAIL stall_done cyc=%0d d=%0d w=%0d exp 15/9/9",
               done_cyc, npop_d, npop_w);
    end
  endtask

  task automatic test_edge_cmds();
    int bad;
    run_op(1, 0, 0, 0, 20);
    checks++;
    if (done_cyc !== 2 || done_n !== 1 || npop_d + npop_w !== 0) begin
      failures++;
      $display("FAIL zero_op cyc=%0d n=%0d pops=%0d exp 2/1/0",
               done_cyc, done_n, npop_d + npop_w);
    end
    clear_stats();
    op_conv = 1'b0;
    start = 1'b1; op_type = 3'd7; op_num = 5;
    opnd_ready = 1'b1;
    cycle();
    start = 1'b0;
    repeat (4) cycle();
    checks++;
    if (err_cyc !== 1 || err_n !== 1) begin
      failures++;
      $display("FAIL illegal_err cyc=%0d n=%0d exp 1/1", err_cyc, err_n);
    end
    checks++;
    if (busy_n !== 0 || npop_d !== 0 || done_n !== 0) begin
      failures++;
      $display("FAIL illegal_quiet busy=%0d pops=%0d done=%0d exp 0",
               busy_n, npop_d, done_n);
    end
    fill_random(16);
    run_op(2, 4, 0, 1, 40);
    bad = 0;
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= got.size() || got[i] !== exp_q[i]) bad++;
    checks++;
    if (bad !== 0 || got.size() !== 4) begin
      failures++;
      $display("FAIL busy_start_pairs bad=%0d n=%0d exp 0/4", bad, got.size());
    end
    checks++;
    if (err_n !== 0 || done_n !== 1 || busy_n !== 5 || npop_w !== 4) begin
      failures++;
      $display("FAIL busy_start err=%0d done=%0d busy=%0d w=%0d exp 0/1/5/4",
               err_n, done_n, busy_n, npop_w);
    end
  endtask

  task automatic test_reset_mid_op();
    int p0, bad;
    fill_random(24);
    clear_stats();
    op_conv = 1'b1;
    op_type = 3'd2; op_num = 9; start = 1'b1; opnd_ready = 1'b1;
    cycle();
    start = 1'b0;
    while (nhs < 5 && cyc < 40) cycle();
    p0 = npop_d;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    checks++;
    if (npop_d !== p0) begin
      failures++;
      $display("FAIL rst_pop got=%0d exp=%0d", npop_d, p0);
    end
    #1;
    checks++;
    if ({opnd_valid, opnd_last, opnd_data, opnd_weight, busy, done, err,
         data_fifo_rd_en, weight_fifo_rd_en} !== '0) begin
      failures++;
      $display("FAIL rst_outputs v=%b d=%h busy=%b rd=%b exp 0",
               opnd_valid, opnd_data, busy, data_fifo_rd_en);
    end
    repeat (4) cycle();
    checks++;
    if (done_n !== 0 || npop_d !== p0) begin
      failures++;
      $display("FAIL rst_quiet done=%0d pops=%0d exp 0/%0d",
               done_n, npop_d, p0);
    end
    run_op(2, 3, 0, 0, 30);
    bad = 0;
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= got.size() || got[i] !== exp_q[i]) bad++;
    checks++;
    if (bad !== 0 || got.size() !== 3 || done_cyc !== 5) begin
      failures++;
      $display("FAIL rst_next bad=%0d n=%0d done=%0d exp 0/3/5",
               bad, got.size(), done_cyc);
    end
  endtask

  task automatic test_random_ops();
    int bad, typ, num;
    for (int k = 0; k < 8; k++) begin
      typ = $urandom_range(4, 1);
      num = $urandom_range(12, 1);
      fill_random(16);
      rnd_empty = 1'b1;
      run_op(typ, num, 2, 0, 300);
      rnd_empty = 1'b0;
      bad = 0;
      for (int i = 0; i < exp_q.size(); i++)
        if (i >= got.size() || got[i] !== exp_q[i]) bad++;
      checks++;
      if (bad !== 0 || got.size() !== num || done_n !== 1) begin
        failures++;
        $display("FAIL rand_op%0d t=%0d n=%0d bad=%0d got=%0d done=%0d",
                 k, typ, num, bad, got.size(), done_n);
      end
      checks++;
      if (npop_d !== num || npop_w !== (op_conv ? num : 0)
          || v_empty + v_wpool + v_lock + v_occ + v_hold !== 0) begin
        failures++;
        $display("FAIL rand_rd%0d d=%0d w=%0d viol=%0d exp %0d",
                 k, npop_d, npop_w,
                 v_empty + v_wpool + v_lock + v_occ + v_hold, num);
      end
    end
  endtask

  initial begin
    rnd_empty = 1'b0;
    op_conv = 1'b0;
    data_fifo_empty = 1'b1;
    weight_fifo_empty = 1'b1;
    @(negedge clk);
    test_reset();
    test_conv_stream();
    test_ready_toggle();
    test_maxpool();
    test_weight_stall();
    test_edge_cmds();
    test_reset_mid_op();
    test_random_ops();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
